pcie_cq_reg_completer: RTL and testbench

Completer-side PCIe endpoint for the user clock domain. It consumes host-initiated memory requests on the CQ AXI-stream, services single-DW reads and writes against a local 32-bit register file, and returns completions on the CC AXI-stream. It sits between the Gen3 hard-core wrapper's CQ/CC ports and fpga_core control logic. It is the responder to the host's requester, which keeps the RQ/RC DMA path free for device-initiated traffic.

---
 rtl/pcie_cq_reg_completer.sv | 192 +++++++++++++++++++
 tb/tb_pcie_cq_reg_completer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cq_reg_completer.sv
// Single-DW register completer: CQ MemRd/MemWr against a 32-bit register file, CC completions back.
// Optional COMPLETER_UR_EN: unsupported non-posted requests get an Unsupported Request completion.
module pcie_cq_reg_completer #(
  parameter int AXIS_PCIE_DATA_WIDTH    = 256,
  parameter int AXIS_PCIE_KEEP_WIDTH    = 8,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 85,
  parameter int AXIS_PCIE_CC_USER_WIDTH = 33,
  parameter int REG_ADDR_WIDTH          = 5,
  localparam int REG_COUNT              = 2**REG_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                               s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
  input  logic                               s_axis_cq_tvalid,
  output logic                               s_axis_cq_tready,
  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
  output logic                               m_axis_cc_tlast,
  output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,
  output logic                               m_axis_cc_tvalid,
  input  logic                               m_axis_cc_tready,
  input  logic [15:0]                        completer_id,
  output logic [32*REG_COUNT-1:0]            reg_out,
  output logic [REG_COUNT-1:0]               reg_wr_strobe,
  output logic                               status_error_uncor
);

  typedef enum logic [1:0] {ST_IDLE, ST_CPL, ST_DROP} state_t;

  state_t                          r_state;
  logic                            r_cq_tready;
  logic                            r_cc_tvalid;
  logic [127:0]                    r_cc_desc;
  logic [AXIS_PCIE_KEEP_WIDTH-1:0] r_cc_tkeep;
  logic [REG_COUNT-1:0]            r_wr_strobe;
  logic                            r_err;
  logic [31:0]                     r_regs [REG_COUNT];

  logic                      w_cq_fire;
  logic [3:0]                w_req_type;
  logic [10:0]               w_dw_cnt;
  logic [REG_ADDR_WIDTH-1:0] w_index;
  logic [3:0]                w_first_be;
  logic [31:0]               w_wdata;
  logic                      w_is_rd;
  logic                      w_is_wr;
  logic                      w_dw_one;
  logic [1:0]                w_low_pos;
  logic [12:0]               w_byte_cnt;
  logic [127:0]              w_cpl_desc;
  logic                      w_unused;

  assign w_cq_fire  = s_axis_cq_tvalid & r_cq_tready;
  assign w_req_type = s_axis_cq_tdata[78:75];
  assign w_dw_cnt   = s_axis_cq_tdata[74:64];
  assign w_index    = s_axis_cq_tdata[REG_ADDR_WIDTH+1:2];
  assign w_first_be = s_axis_cq_tuser[3:0];
  assign w_wdata    = s_axis_cq_tdata[159:128];
  assign w_is_rd    = (w_req_type == 4'b0000);
  assign w_is_wr    = (w_req_type == 4'b0001);
  assign w_dw_one   = (w_dw_cnt == 11'd1);
  assign w_unused   = ^{s_axis_cq_tkeep, s_axis_cq_tdata, s_axis_cq_tuser};

  // Byte count is the span between the first and last enabled bytes; an empty mask counts as 1.
  always_comb begin
    w_low_pos  = 2'd0;
    w_byte_cnt = 13'd1;
    if (w_first_be[0])      w_low_pos = 2'd0;
    else if (w_first_be[1]) w_low_pos = 2'd1;
    else if (w_first_be[2]) w_low_pos = 2'd2;
    else if (w_first_be[3]) w_low_pos = 2'd3;
    if (w_first_be[0] && w_first_be[3])
      w_byte_cnt = 13'd4;
    else if ((w_first_be[0] && w_first_be[2]) || (w_first_be[1] && w_first_be[3]))
      w_byte_cnt = 13'd3;
    else if ((w_first_be[0] && w_first_be[1]) || (w_first_be[1] && w_first_be[2]) ||
             (w_first_be[2] && w_first_be[3]))
      w_byte_cnt = 13'd2;
  end

  always_comb begin
    w_cpl_desc         = '0;
    w_cpl_desc[6:0]    = {s_axis_cq_tdata[6:2], w_low_pos};
    w_cpl_desc[28:16]  = w_byte_cnt;
    w_cpl_desc[42:32]  = 11'd1;
    w_cpl_desc[63:48]  = s_axis_cq_tdata[95:80];
    w_cpl_desc[71:64]  = s_axis_cq_tdata[103:96];
    w_cpl_desc[87:72]  = completer_id;
    w_cpl_desc[88]     = 1'b1;
    w_cpl_desc[91:89]  = s_axis_cq_tdata[123:121];
    w_cpl_desc[94:92]  = s_axis_cq_tdata[126:124];
    w_cpl_desc[127:96] = r_regs[w_index];
  end

`ifdef COMPLETER_UR_EN
  logic         w_non_posted;
  logic [127:0] w_ur_desc;

  // Memory writes and messages are posted; everything else expects a completion.
  assign w_non_posted = !w_is_wr && (w_req_type[3:2] != 2'b11);

  always_comb begin
    w_ur_desc          = w_cpl_desc;
    w_ur_desc[28:16]   = 13'd0;
    w_ur_desc[42:32]   = 11'd0;
    w_ur_desc[45:43]   = 3'b001;
    w_ur_desc[127:96]  = 32'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cq_tready <= 1'b0;
      r_cc_tvalid <= 1'b0;
      r_cc_desc   <= '0;
      r_cc_tkeep  <= 8'h0F;
      r_wr_strobe <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= '0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cq_tready <= 1'b1;
          if (w_cq_fire) begin
            if (w_is_wr && w_dw_one) begin
              for (int b = 0; b < 4; b++)
                if (w_first_be[b]) r_regs[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
              r_wr_strobe[w_index] <= 1'b1;
              if (!s_axis_cq_tlast) r_state <= ST_DROP;
            end else if (w_is_rd && w_dw_one) begin
              r_cc_desc   <= w_cpl_desc;
              r_cc_tkeep  <= 8'h0F;
              r_cc_tvalid <= 1'b1;
              r_cq_tready <= 1'b0;
              r_state     <= ST_CPL;
            end else begin
              r_err <= 1'b1;
`ifdef COMPLETER_UR_EN
              if (w_non_posted) begin
                r_cc_desc   <= w_ur_desc;
                r_cc_tkeep  <= 8'h07;
                r_cc_tvalid <= 1'b1;
                r_cq_tready <= 1'b0;
                r_state     <= ST_CPL;
              end else if (!s_axis_cq_tlast) begin
                r_state <= ST_DROP;
              end
`else
              if (!s_axis_cq_tlast) r_state <= ST_DROP;
`endif
            end
          end
        end
        ST_CPL: begin
          if (m_axis_cc_tready) begin
            r_cc_tvalid <= 1'b0;
            r_cq_tready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_DROP: begin
          r_cq_tready <= 1'b1;
          if (w_cq_fire && s_axis_cq_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg_out
      assign reg_out[32*gi +: 32] = r_regs[gi];
    end
  endgenerate

  assign s_axis_cq_tready   = r_cq_tready;
  assign m_axis_cc_tdata    = {{(AXIS_PCIE_DATA_WIDTH-128){1'b0}}, r_cc_desc};
  assign m_axis_cc_tkeep    = r_cc_tkeep;
  assign m_axis_cc_tlast    = 1'b1;
  assign m_axis_cc_tuser    = '0;
  assign m_axis_cc_tvalid   = r_cc_tvalid;
  assign reg_wr_strobe      = r_wr_strobe;
  assign status_error_uncor = r_err;

endmodule

// File: tb/tb_pcie_cq_reg_completer.sv
// Self-checking bench for pcie_cq_reg_completer: directed steps plus randomized traffic
// checked against a register-array model. Honours COMPLETER_UR_EN when defined.
module tb_pcie_cq_reg_completer;
  localparam int RC = 32;
`ifdef COMPLETER_UR_EN
  localparam bit UR = 1'b1;
`else
  localparam bit UR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [255:0]    cq_tdata;
  logic [7:0]      cq_tkeep;
  logic            cq_tlast;
  logic [84:0]     cq_tuser;
  logic            cq_tvalid;
  logic            cq_tready;
  logic [255:0]    cc_tdata;
  logic [7:0]      cc_tkeep;
  logic            cc_tlast;
  logic [32:0]     cc_tuser;
  logic            cc_tvalid;
  logic            cc_tready;
  logic [15:0]     completer_id;
  logic [32*RC-1:0] reg_out;
  logic [RC-1:0]   reg_wr_strobe;
  logic            err;

  int n_cmp = 0;
  int n_fail = 0;
  int n_cc_seen = 0;
  int n_cc_exp = 0;
  logic [31:0] model [RC];

  pcie_cq_reg_completer dut (
    .clk(clk), .rst(rst),
    .s_axis_cq_tdata(cq_tdata), .s_axis_cq_tkeep(cq_tkeep), .s_axis_cq_tlast(cq_tlast),
    .s_axis_cq_tuser(cq_tuser), .s_axis_cq_tvalid(cq_tvalid), .s_axis_cq_tready(cq_tready),
    .m_axis_cc_tdata(cc_tdata), .m_axis_cc_tkeep(cc_tkeep), .m_axis_cc_tlast(cc_tlast),
    .m_axis_cc_tuser(cc_tuser), .m_axis_cc_tvalid(cc_tvalid), .m_axis_cc_tready(cc_tready),
    .completer_id(completer_id), .reg_out(reg_out), .reg_wr_strobe(reg_wr_strobe),
    .status_error_uncor(err)
  );

  always #2 clk = ~clk;

  always @(posedge clk) if (!rst && cc_tvalid && cc_tready) n_cc_seen++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [3:0] typ, input logic [10:0] dw,
      input logic [63:0] addr, input logic [15:0] rid, input logic [7:0] tag,
      input logic [2:0] tc, input logic [2:0] attr, input logic [31:0] data);
    logic [255:0] d;
    d = '0;
    d[63:0]    = {addr[63:2], 2'b00};
    d[74:64]   = dw;
    d[78:75]   = typ;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[123:121] = tc;
    d[126:124] = attr;
    d[159:128] = data;
    return d;
  endfunction

  function automatic logic [127:0] exp_cc(input logic [63:0] addr, input logic [3:0] be,
      input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
      input logic [2:0] attr, input logic [31:0] data, input bit ur);
    logic [127:0] e;
    int first, last;
    first = -1;
    last = -1;
    for (int b = 0; b < 4; b++) if (be[b]) begin
      if (first < 0) first = b;
      last = b;
    end
    if (first < 0) begin first = 0; last = 0; end
    e = '0;
    e[6:0] = 7'((int'(addr[6:2]) * 4) + first);
    if (ur) begin
      e[45:43] = 3'b001;
    end else begin
      e[28:16]  = 13'(last - first + 1);
      e[42:32]  = 11'd1;
      e[127:96] = data;
    end
    e[63:48] = rid;
    e[71:64] = tag;
    e[87:72] = completer_id;
    e[88]    = 1'b1;
    e[91:89] = tc;
    e[94:92] = attr;
    return e;
  endfunction

  // Presents one beat; the DUT should be ready immediately since every step starts from IDLE.
  task automatic send_beat(input logic [255:0] d, input logic [3:0] be, input logic last);
    bit ok;
    ok = 1'b0;
    cq_tdata  = d;
    cq_tuser  = '0;
    cq_tuser[3:0] = be;
    cq_tlast  = last;
    cq_tkeep  = 8'hFF;
    cq_tvalid = 1'b1;
    check("cq_ready_at_start", 128'(cq_tready), 128'(1));
    for (int w = 0; w < 32 && !ok; w++) begin
      if (cq_tready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    cq_tvalid = 1'b0;
    if (!ok) check("cq_accept_timeout", 128'(ok), 128'(1));
  endtask

  task automatic do_wr(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] be,
      input logic [10:0] dw, input bit multi);
    int idx;
    logic [31:0] es;
    bit good;
    idx  = int'(addr[6:2]);
    good = (dw == 11'd1);
    send_beat(mk(4'b0001, dw, addr, 16'h0, 8'h0, 3'd0, 3'd0, data), be, !multi);
    es = '0;
    if (good) begin
      es[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    $display("WR  addr=%h be=%b dw=%0d data=%h multi=%0d", addr, be, dw, data, multi);
    check("wr_strobe", 128'(reg_wr_strobe), 128'(es));
    check("wr_err", 128'(err), 128'(!good));
    check("wr_reg", 128'(reg_out[32*idx +: 32]), 128'(model[idx]));
    check("wr_no_cc", 128'(cc_tvalid), 128'(0));
    if (multi) begin
      send_beat(mk(4'b0001, 11'd1, {$urandom, $urandom}, 16'h0, 8'h0, 3'd0, 3'd0, $urandom),
                4'hF, 1'b1);
      check("drop_strobe", 128'(reg_wr_strobe), 128'(0));
      check("drop_err", 128'(err), 128'(0));
    end
  endtask

  task automatic do_rd(input logic [3:0] typ, input logic [63:0] addr, input logic [3:0] be,
      input logic [10:0] dw, input logic [15:0] rid, input logic [7:0] tag,
      input logic [2:0] tc, input logic [2:0] attr, input int stall);
    bit good, np, expect_cpl;
    logic [127:0] e;
    logic [7:0] ek;
    good = (typ == 4'd0) && (dw == 11'd1);
    np   = !((typ == 4'd1) || (typ >= 4'd12));
    expect_cpl = good || (UR && np);
    e  = exp_cc(addr, be, rid, tag, tc, attr, model[int'(addr[6:2])], !good);
    ek = good ? 8'h0F : 8'h07;
    send_beat(mk(typ, dw, addr, rid, tag, tc, attr, $urandom), be, 1'b1);
    $display("RD  typ=%0d addr=%h be=%b dw=%0d tag=%h cpl=%0d stall=%0d", typ, addr, be, dw,
             tag, expect_cpl, stall);
    check("rd_err", 128'(err), 128'(!good));
    check("rd_strobe", 128'(reg_wr_strobe), 128'(0));
    check("rd_cc_valid", 128'(cc_tvalid), 128'(expect_cpl));
    if (expect_cpl) begin
      check("cc_desc", cc_tdata[127:0], e);
      check("cc_upper", cc_tdata[255:128], 128'(0));
      check("cc_tkeep", 128'(cc_tkeep), 128'(ek));
      check("cc_tlast", 128'(cc_tlast), 128'(1));
      check("cc_tuser", 128'(cc_tuser), 128'(0));
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("stall_valid", 128'(cc_tvalid), 128'(1));
        check("stall_desc", cc_tdata[127:0], e);
        check("stall_cq_ready", 128'(cq_tready), 128'(0));
      end
      cc_tready = 1'b1;
      @(posedge clk); #1;
      cc_tready = 1'b0;
      n_cc_exp++;
      check("cc_count", 128'(n_cc_seen), 128'(n_cc_exp));
      check("cc_valid_after", 128'(cc_tvalid), 128'(0));
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [3:0]  typ;
    cq_tdata = '0; cq_tkeep = '0; cq_tlast = 1'b0; cq_tuser = '0; cq_tvalid = 1'b0;
    cc_tready = 1'b0;
    completer_id = 16'(32'hA5C3 ^ $urandom_range(0, 255));
    rst = 1'b1;
    for (int i = 0; i < RC; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cq_ready", 128'(cq_tready), 128'(0));
    check("rst_cc_valid", 128'(cc_tvalid), 128'(0));
    check("rst_strobe", 128'(reg_wr_strobe), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cq_ready", 128'(cq_tready), 128'(1));
    check("post_rst_regs_zero", 128'(reg_out == '0), 128'(1));

    do_wr(64'h0C, 32'hDEADBEEF, 4'hF, 11'd1, 1'b0);
    check("tp_wr_full", 128'(reg_out[127:96]), 128'(32'hDEADBEEF));
    do_wr(64'h0C, 32'h11223344, 4'h5, 11'd1, 1'b0);
    check("tp_wr_partial", 128'(reg_out[127:96]), 128'(32'hDE22BE44));
    do_rd(4'd0, 64'h0C, 4'hF, 11'd1, 16'h0100, 8'h2A, 3'd0, 3'd0, 0);
    do_rd(4'd0, 64'h0C, 4'h9, 11'd1, 16'h0100, 8'h2B, 3'd2, 3'd5, 10);
    do_rd(4'd0, 64'h0C, 4'hF, 11'd4, 16'h0100, 8'h2C, 3'd0, 3'd0, 0);
    do_wr(64'hFFFF_0000_0000_0084, 32'hCAFEF00D, 4'hF, 11'd1, 1'b1);
    do_rd(4'd0, 64'h04, 4'h6, 11'd1, 16'h0200, 8'h01, 3'd1, 3'd1, 0);

    for (int t = 0; t < 80; t++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_wr(a, $urandom, 4'($urandom_range(0, 15)), 11'd1,
                          $urandom_range(0, 4) == 0);
        4, 5, 6: do_rd(4'd0, a, 4'($urandom_range(0, 15)), 11'd1, 16'($urandom),
                       8'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 3));
        7: do_rd(4'd0, a, 4'($urandom_range(0, 15)), 11'($urandom_range(2, 2047)),
                 16'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 1);
        8: do_wr(a, $urandom, 4'hF, 11'($urandom_range(2, 2047)), $urandom_range(0, 1) == 1);
        default: begin
          case ($urandom_range(0, 3))
            0: typ = 4'd2;
            1: typ = 4'd8;
            2: typ = 4'd12;
            default: typ = 4'd13;
          endcase
          do_rd(typ, a, 4'($urandom_range(0, 15)), 11'd1, 16'($urandom), 8'($urandom),
                3'($urandom), 3'($urandom), 0);
        end
      endcase
    end

    // Reset while a completion is pending.
    send_beat(mk(4'd0, 11'd1, 64'h08, 16'h0300, 8'h77, 3'd0, 3'd0, 32'h0), 4'hF, 1'b1);
    $display("RST during CPL");
    check("pre_rst_cc_valid", 128'(cc_tvalid), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cc_valid", 128'(cc_tvalid), 128'(0));
    check("mid_rst_regs_zero", 128'(reg_out == '0), 128'(1));
    for (int i = 0; i < RC; i++) model[i] = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_cq_ready", 128'(cq_tready), 128'(1));
    do_rd(4'd0, 64'h00, 4'hF, 11'd1, 16'h0400, 8'h10, 3'd0, 3'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
